// File: rtl/lut_ram.sv
// lut_ram: 256x8 lookup table with 1-cycle registered read and beat-wise reprogramming
module lut_ram #(
    parameter int BEAT_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              x_i,
    output logic [7:0]              y_o,
    input  logic                    load_start,
    input  logic                    ld_valid,
    input  logic [BEAT_BYTES*8-1:0] ld_data,
    output logic                    ld_ready,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    table_valid
);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t     state_q, state_d;
    logic [7:0] wp_q, wp_d, y_q, y_d;
    logic       done_q, done_d, tv_q, tv_d;
    logic [7:0] mem_q [256];
    logic [7:0] mem_d [256];
    logic       last;
    assign last = wp_q == 8'(256 - BEAT_BYTES);
    // read uses mem_q, so a same-cycle write to the looked-up entry returns the old value
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        tv_d    = tv_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        y_d     = mem_q[x_i];
        if (load_start) begin
            state_d = LOAD;
            wp_d    = '0;
            tv_d    = 1'b0;
        end else if (state_q == LOAD && ld_valid) begin
            for (int k = 0; k < BEAT_BYTES; k++)
                mem_d[wp_q + 8'(k)] = ld_data[8*k +: 8];
            wp_d = wp_q + 8'(BEAT_BYTES);
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
                tv_d    = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            tv_q    <= 1'b0;
            for (int i = 0; i < 256; i++) mem_q[i] <= 8'(i);
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            y_q     <= y_d;
            done_q  <= done_d;
            tv_q    <= tv_d;
            mem_q   <= mem_d;
        end
    end
    assign y_o         = y_q;
    assign ld_ready    = state_q == LOAD;
    assign load_busy   = state_q == LOAD;
    assign load_done   = done_q;
    assign table_valid = tv_q;
endmodule

// File: tb/tb_lut_ram.sv
// tb_lut_ram: directed and random checks of lut_ram against a per-entry table model
module tb_lut_ram;
    localparam int BB = 4;
    logic          clk, rst_n, ls, v;
    logic [7:0]    x;
    logic [BB*8-1:0] d;
    logic [7:0]    y_o;
    logic          ld_ready, load_busy, load_done, table_valid;
    logic [7:0]    m_tab [256];
    int            m_wp;
    bit            m_load, m_valid;
    int            errors = 0, checks = 0, n_done = 0, base;

    lut_ram #(.BEAT_BYTES(BB)) dut (
        .clk(clk), .rst_n(rst_n), .x_i(x), .y_o(y_o), .load_start(ls),
        .ld_valid(v), .ld_data(d), .ld_ready(ld_ready), .load_busy(load_busy),
        .load_done(load_done), .table_valid(table_valid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BB*8-1:0] inv_beat(input int wp);
        logic [BB*8-1:0] r;
        for (int k = 0; k < BB; k++) r[8*k +: 8] = ~8'(wp + k);
        return r;
    endfunction

    task automatic step();
        logic [7:0] ey;
        bit ed;
        @(posedge clk);
        ey = m_tab[x];
        ed = 0;
        if (ls) begin
            m_load = 1; m_wp = 0; m_valid = 0;
        end else if (m_load && v) begin
            for (int k = 0; k < BB; k++) m_tab[(m_wp + k) % 256] = d[8*k +: 8];
            m_wp += BB;
            if (m_wp == 256) begin
                m_wp = 0; m_load = 0; m_valid = 1; ed = 1;
            end
        end
        #1;
        if (load_done) n_done++;
        chk("y_o", y_o, ey);
        chk("load_done", 8'(load_done), 8'(ed));
        chk("table_valid", 8'(table_valid), 8'(m_valid));
        chk("ld_ready", 8'(ld_ready), 8'(m_load));
        chk("load_busy", 8'(load_busy), 8'(m_load));
    endtask

    task automatic do_reset();
        rst_n = 0; ls = 0; v = 0;
        #1;
        for (int i = 0; i < 256; i++) m_tab[i] = 8'(i);
        m_wp = 0; m_load = 0; m_valid = 0;
        chk("rst_y_o", y_o, 8'h00);
        chk("rst_load_done", 8'(load_done), 8'h00);
        chk("rst_table_valid", 8'(table_valid), 8'h00);
        chk("rst_ld_ready", 8'(ld_ready), 8'h00);
        chk("rst_load_busy", 8'(load_busy), 8'h00);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
    endtask

    task automatic sweep();
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            step();
        end
    endtask

    initial begin
        x = 0; d = '0;
        do_reset();
        sweep();
        // full inverted load, back-to-back
        ls = 1; step(); ls = 0;
        for (int i = 0; i < 64; i++) begin
            v = 1; d = inv_beat(m_wp); x = 8'($urandom); step();
        end
        v = 0; step();
        sweep();
        x = 8'h12; step();
        chk("inv_12", y_o, 8'hED);
        // same load with ld_valid toggling
        base = n_done;
        ls = 1; step(); ls = 0;
        for (int i = 0; i < 128; i++) begin
            v = i[0]; d = inv_beat(m_wp); x = 8'($urandom); step();
        end
        v = 0; step();
        chk("toggle_done_count", 8'(n_done - base), 8'd1);
        chk("toggle_tv", 8'(table_valid), 8'd1);
        sweep();
        // restart after 10 beats, then all 0x5A
        base = n_done;
        ls = 1; step(); ls = 0;
        for (int i = 0; i < 10; i++) begin
            v = 1; d = BB*8'($urandom); d = {$urandom}; step();
        end
        ls = 1; v = 1; d = {$urandom}; step(); ls = 0;
        for (int i = 0; i < 64; i++) begin
            v = 1; d = {BB{8'h5A}}; step();
        end
        v = 0; step();
        chk("restart_done_count", 8'(n_done - base), 8'd1);
        sweep();
        x = 8'h03; step();
        chk("restart_03", y_o, 8'h5A);
        // load_start colliding with the last beat
        base = n_done;
        ls = 1; step(); ls = 0;
        for (int i = 0; i < 63; i++) begin
            v = 1; d = {$urandom}; step();
        end
        ls = 1; v = 1; d = {$urandom}; step(); ls = 0;
        chk("collide_no_done", 8'(n_done - base), 8'd0);
        for (int i = 0; i < 64; i++) begin
            v = 1; d = inv_beat(m_wp); step();
        end
        v = 0; step();
        chk("collide_done_count", 8'(n_done - base), 8'd1);
        sweep();
        // read-before-write on entry 0x08
        do_reset();
        ls = 1; step(); ls = 0;
        for (int i = 0; i < 2; i++) begin
            v = 1; d = {$urandom}; step();
        end
        v = 1; d = {BB{8'hAA}}; x = 8'h08; step();
        chk("rbw_old", y_o, 8'h08);
        v = 0; x = 8'h08; step();
        chk("rbw_new", y_o, 8'hAA);
        // reset in the middle of a load
        base = n_done;
        for (int i = 0; i < 17; i++) begin
            v = 1; d = {$urandom}; step();
        end
        #2;
        do_reset();
        x = 8'h10; step();
        chk("mid_reset_10", y_o, 8'h10);
        chk("mid_reset_no_done", 8'(n_done - base), 8'd0);
        chk("mid_reset_tv", 8'(table_valid), 8'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            ls = ($urandom_range(0, 199) == 0);
            v  = $urandom_range(0, 3) != 0;
            d  = {$urandom};
            x  = 8'($urandom);
            step();
        end
        ls = 0; v = 0;
        sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_ram.md
LUT_RAM -- requirements
Module: lut_ram

Interface
REQ-001: Parameter BEAT_BYTES, default 4; table bytes accepted per load beat; SHALL be 1, 2, 4, 8 or 16.
REQ-002: Table depth is fixed at 256 entries x 8 bit, indexed by the 8-bit lookup operand.
REQ-003: clk  input  1  clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: x_i  input  8  lookup index from the LUT sequencer.
REQ-006: y_o  output  8  registered lookup result for the x_i sampled on the previous edge.
REQ-007: load_start  input  1  single-cycle request to (re)program the whole table.
REQ-008: ld_valid  input  1  load beat valid.
REQ-009: ld_data  input  BEAT_BYTES*8  load beat payload; byte k at bits [8k+7:8k].
REQ-010: ld_ready  output  1  block accepts a load beat this cycle.
REQ-011: load_busy  output  1  high while in LOAD state.
REQ-012: load_done  output  1  one-cycle pulse after the final beat is written.
REQ-013: table_valid  output  1  table fully programmed since reset.

Function
REQ-014: Lookup SHALL have exactly 1 cycle latency: y_o <= table[x_i] every cycle, no enable, no stall.
REQ-015: Lookup SHALL operate in both IDLE and LOAD states, returning current table contents.
REQ-016: Read and load write to the same entry in the same cycle SHALL return the pre-write value (read-before-write).
REQ-017: FSM states IDLE and LOAD; reset state IDLE.
REQ-018: IDLE: ld_ready=0, load_busy=0; load_start=1 -> LOAD, write pointer wp <= 0, table_valid <= 0.
REQ-019: LOAD: ld_ready=1, load_busy=1; a beat is accepted when ld_valid && ld_ready.
REQ-020: Accepted beat SHALL write byte k of ld_data to table[wp+k] for k = 0..BEAT_BYTES-1, then wp <= wp + BEAT_BYTES.
REQ-021: wp width 8 bits; the beat accepted with wp == 256-BEAT_BYTES is the last beat: LOAD -> IDLE, wp wraps to 0.
REQ-022: load_done SHALL be 1 for exactly the cycle after the last-beat edge; table_valid SHALL go 1 on the same edge as load_done and stay 1 until the next load_start or reset.
REQ-023: ld_valid in IDLE SHALL be ignored (no write, no pointer change).
REQ-024: load_start in LOAD SHALL restart: wp <= 0, any beat presented in that cycle discarded, stay LOAD, no load_done.
REQ-025: load_start in the same cycle as the last beat SHALL take priority: beat discarded, restart per REQ-024.
REQ-026: Partially loaded tables keep already-written entries; unwritten entries retain their previous contents.
REQ-027: ld_valid low in LOAD SHALL hold wp and state indefinitely (no timeout).

Reset
REQ-028: On rst_n low, asynchronously: state IDLE, wp=0, y_o=0, load_done=0, table_valid=0, ld_ready=0, load_busy=0.
REQ-029: On reset every entry SHALL be set to identity, table[i]=i, so unprogrammed lookups pass through.
REQ-030: Reset during LOAD SHALL abandon the load with no load_done; table returns to identity.

Verification
REQ-031: After reset, x_i=0x00..0xFF swept one per cycle -> y_o equals previous-cycle x_i each cycle; table_valid=0.
REQ-032: BEAT_BYTES=4, load_start then 64 back-to-back beats with ld_data byte k = ~(wp+k) -> load_done pulses 1 cycle after beat 64, table_valid=1; sweep gives y_o = ~x.
REQ-033: Same load with ld_valid toggling every other cycle -> 64 beats accepted over 128 cycles, identical final table, exactly one load_done.
REQ-034: load_start reasserted after 10 beats, then 64 beats of 0x5A -> all entries 0x5A, one load_done; entries 0..39 not left with first-pass data.
REQ-035: x_i=0x08 while beat writing 0x08..0x0B with 0xAA -> y_o returns old value (0x08 from identity) next cycle, 0xAA on the following lookup.
REQ-036: rst_n pulsed low after 20 beats -> no load_done, table_valid=0, lookup of 0x10 returns 0x10.
